mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  LC-3b pipeline MEM stage. It is the consumer of the execute stage's result bus:
//  the ALU result, the MAR-mux address, the store word and the byte-store select.
//  It issues the data-memory request/response handshake for LDR/LDB/STR/STB/LDI/STI
//  and stalls the pipeline until the access completes. Ops that use no memory pass
//  straight through. Results are registered into the MEM/WB latch that feeds the
//  writeback stage and the forwarding path.
// PARAMETERS
//  none (widths come from lc3b_types: lc3b_word=16, lc3b_reg=3)
// PORTS
//  clk             in   1   clock; all state updates on the rising edge
//  reset           in   1   asynchronous, active-high reset
//  in_valid        in   1   EX/MEM latch holds a valid instruction
//  mem_op          in   3   lc3b_memop: MOP_NONE,LDR,LDB,STR,STB,LDI,STI
//  addr_in         in   16  effective address (execute-stage MAR-mux output)
//  alu_in          in   16  ALU result, passed through for MOP_NONE
//  store_data      in   16  store source register value
//  dest_in         in   3   destination register
//  regwrite_in     in   1   instruction writes the register file
//  stall           out  1   hold the upstream pipeline registers (combinational)
//  dmem_address    out  16  data memory address
//  dmem_read       out  1   read request
//  dmem_write      out  1   write request
//  dmem_wdata      out  16  write data
//  dmem_byte_en    out  2   byte enables, [1]=high byte
//  dmem_rdata      in   16  read data, valid when dmem_resp=1
//  dmem_resp       in   1   one-cycle completion pulse
//  wb_valid        out  1   MEM/WB latch valid (registered)
//  wb_data         out  16  load data or ALU result (registered)
//  wb_dest         out  3   registered dest_in
//  wb_regwrite     out  1   registered regwrite_in, forced to 0 when wb_valid=0
// BEHAVIOUR
//  - Reset: state=FIRST, ptr=0, and every registered output is 0. dmem_read and
//    dmem_write are 0 while reset is asserted. Reset in the middle of an access
//    abandons it; no writeback and no further request is made.
//  - FSM FIRST/SECOND. Requests are driven combinationally from the state and the inputs.
//    FIRST with in_valid and mem_op!=NONE: request at addr_in.
//      resp and op is not indirect -> done.
//      resp and op is LDI/STI -> ptr<=dmem_rdata, go to SECOND.
//    SECOND: request at ptr. LDI reads, STI writes.
//      resp -> done, return to FIRST.
//  - Word accesses (LDR/STR, the indirect pointer read, and the final LDI/STI access)
//    force address[0]=0 and set byte_en=2'b11.
//  - STB: byte_en = addr_in[0] ? 2'b10 : 2'b01; wdata={store_data[7:0],store_data[7:0]}.
//  - LDB: wb_data = sign-extended byte, high byte if addr_in[0]=1 else low byte.
//  - Loads return dmem_rdata. Stores give wb_data=0 and wb_regwrite=0.
//  - stall = in_valid & (mem_op!=NONE) & !done. Stall is low in the done cycle, so
//    the upstream latch and MEM/WB advance on that edge.
//  - MOP_NONE: no request, no stall. MEM/WB captures alu_in on the next edge:
//    1-cycle latency.
//  - Memory latency: resp may arrive in the same cycle the request is raised
//    (0 wait states), or any number of cycles later. Address, data and enables are
//    held stable until resp. dmem_resp is ignored when no request is outstanding.
//  - Cycles where the stage is stalled and not done load wb_valid=0 (a bubble).
//  - Upstream inputs are held stable while stall=1. The stage does not re-sample them.
// STRUCTURE
//  - lc3b_types gains the lc3b_memop enum and the constant BYTE_EN_WORD=2'b11.
//  - Sub-module mem_byte_align (combinational): inputs op, addr[0], store_data and
//    rdata; outputs byte_en, wdata and load data.
//  - Everything else lives in this file: the FSM, the ptr register and the MEM/WB
//    register.
// TESTING
//  1. MOP_NONE, alu_in=16'h1234, dest=3 -> next edge wb_valid=1, wb_data=1234,
//     wb_dest=3; stall never asserted.
//  2. LDR addr=16'h3001, resp after 2 cycles with rdata=16'hBEEF ->
//     dmem_address=3000, read held 3 cycles, stall high 2 cycles, wb_data=BEEF.
//  3. LDB addr=16'h2005, rdata=16'h8012, zero-wait resp -> wb_data=FF80.
//     Repeat with addr=2004 -> wb_data=0012.
//  4. STB addr=16'h4000, store_data=16'hAB5C -> byte_en=01, wdata=5C5C,
//     wb_regwrite=0. Repeat with addr=4001 -> byte_en=10.
//  5. LDI addr=16'h1000: first rdata=16'h2000, then rdata=16'h7777 ->
//     two reads (1000, then 2000), wb_data=7777.
//     STI: second access is a write to the pointer with wdata=store_data.
//  6. Assert reset while in SECOND of an LDI -> read drops immediately, state=FIRST,
//     wb_valid=0. A later resp pulse has no effect.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared LC-3b types for the MEM stage: word/register widths, memory-op encoding
// and small op-classification helpers.
package mem_access_stage_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [2:0] {
    MOP_NONE,
    MOP_LDR,
    MOP_LDB,
    MOP_STR,
    MOP_STB,
    MOP_LDI,
    MOP_STI
  } lc3b_memop;

  localparam logic [1:0] BYTE_EN_WORD = 2'b11;

  function automatic logic is_indirect(input lc3b_memop op);
    return (op == MOP_LDI) || (op == MOP_STI);
  endfunction

  function automatic logic is_store(input lc3b_memop op);
    return (op == MOP_STR) || (op == MOP_STB) || (op == MOP_STI);
  endfunction

endpackage

// File: rtl/mem_access_stage_byte_align.sv
// Byte-lane steering for the MEM stage: byte enables and replicated store data for
// STB, sign-extended byte extraction for LDB; word ops pass data through unchanged.
module mem_byte_align
  import mem_access_stage_pkg::*;
(
  input  lc3b_memop  op,
  input  logic       addr_lsb,
  input  lc3b_word   store_data,
  input  lc3b_word   rdata,
  output logic [1:0] byte_en,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte  = addr_lsb ? rdata[15:8] : rdata[7:0];
    byte_en   = BYTE_EN_WORD;
    wdata     = store_data;
    load_data = rdata;
    if ((op == MOP_LDB) || (op == MOP_STB)) begin
      byte_en = addr_lsb ? 2'b10 : 2'b01;
    end
    if (op == MOP_STB) begin
      wdata = {2{store_data[7:0]}};
    end
    if (op == MOP_LDB) begin
      load_data = {{8{sel_byte[7]}}, sel_byte};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: issues data-memory accesses (including two-step indirect LDI/STI),
// stalls upstream until the access completes, and registers the MEM/WB latch.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  lc3b_memop  mem_op,
  input  lc3b_word   addr_in,
  input  lc3b_word   alu_in,
  input  lc3b_word   store_data,
  input  lc3b_reg    dest_in,
  input  logic       regwrite_in,
  output logic       stall,
  output lc3b_word   dmem_address,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_wdata,
  output logic [1:0] dmem_byte_en,
  input  lc3b_word   dmem_rdata,
  input  logic       dmem_resp,
  output logic       wb_valid,
  output lc3b_word   wb_data,
  output lc3b_reg    wb_dest,
  output logic       wb_regwrite
);

  typedef enum logic {StFirst, StSecond} state_e;

  state_e     state_q;
  lc3b_word   ptr_q;
  logic       active, indirect, second, done, advance;
  logic [1:0] align_be;
  lc3b_word   align_wdata, load_data;

  mem_byte_align u_align (
    .op         (mem_op),
    .addr_lsb   (addr_in[0]),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .byte_en    (align_be),
    .wdata      (align_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    active       = in_valid && (mem_op != MOP_NONE);
    indirect     = is_indirect(mem_op);
    second       = (state_q == StSecond);
    done         = active && dmem_resp && (second || !indirect);
    stall        = active && !done;
    advance      = in_valid && !stall;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = addr_in;
    dmem_byte_en = align_be;
    dmem_wdata   = align_wdata;
    // Requests are gated by reset so an abandoned access drops immediately.
    if (active && !reset) begin
      if (second) begin
        dmem_address = {ptr_q[15:1], 1'b0};
        dmem_byte_en = BYTE_EN_WORD;
        dmem_wdata   = store_data;
        dmem_read    = (mem_op == MOP_LDI);
        dmem_write   = (mem_op == MOP_STI);
      end else begin
        dmem_read  = (mem_op == MOP_LDR) || (mem_op == MOP_LDB) || indirect;
        dmem_write = (mem_op == MOP_STR) || (mem_op == MOP_STB);
        if ((mem_op != MOP_LDB) && (mem_op != MOP_STB)) begin
          dmem_address[0] = 1'b0;
          dmem_byte_en    = BYTE_EN_WORD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFirst;
      ptr_q       <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      if (active && dmem_resp && indirect && !second) begin
        ptr_q   <= dmem_rdata;
        state_q <= StSecond;
      end else if (done || !active) begin
        state_q <= StFirst;
      end
      wb_valid    <= advance;
      wb_regwrite <= advance && regwrite_in && !is_store(mem_op);
      if (advance) begin
        wb_dest <= dest_in;
        if (mem_op == MOP_NONE) begin
          wb_data <= alu_in;
        end else if (is_store(mem_op)) begin
          wb_data <= '0;
        end else begin
          wb_data <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset-abandon
// sequence and randomized ops checked against a word-addressed memory model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  lc3b_memop  mem_op = MOP_NONE;
  logic [15:0] addr_in = '0, alu_in = '0, store_data = '0, dmem_rdata = '0;
  logic [2:0] dest_in = '0;
  logic       regwrite_in = 1'b0, dmem_resp = 1'b0;
  logic       stall, dmem_read, dmem_write, wb_valid, wb_regwrite;
  logic [15:0] dmem_address, dmem_wdata, wb_data;
  logic [1:0] dmem_byte_en;
  logic [2:0] wb_dest;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] mem [logic [15:0]];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  be;
    logic        chk_be;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } acc_t;

  typedef struct {
    lc3b_memop   op;
    logic [15:0] addr, alu, sd, rd1, rd2;
    logic [2:0]  dest;
    logic        rw;
    int          lat;
    logic [15:0] exp_wb;
    logic        chk_be;
    logic [1:0]  exp_be;
  } vec_t;

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .mem_op       (mem_op),
    .addr_in      (addr_in),
    .alu_in       (alu_in),
    .store_data   (store_data),
    .dest_in      (dest_in),
    .regwrite_in  (regwrite_in),
    .stall        (stall),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_regwrite  (wb_regwrite)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : {a[7:0], ~a[15:8]};
  endfunction

  // Called just after a rising edge; returns just after the edge that completes the op.
  task automatic do_op(input lc3b_memop op, input logic [15:0] addr, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [2:0] dest, input logic rw,
                       input int lat, output logic [15:0] got_wb, output logic [1:0] got_be);
    acc_t        q[$];
    logic [15:0] w, p, d, exp_wb, cur;
    logic [7:0]  b8;
    logic [1:0]  be;
    logic        last;
    w      = {addr[15:1], 1'b0};
    exp_wb = 16'h0000;
    got_be = 2'b00;
    case (op)
      MOP_LDR: begin
        d = rd(w);
        q.push_back('{1'b0, w, 2'b11, 1'b1, 16'h0, d});
        exp_wb = d;
      end
      MOP_LDB: begin
        d  = rd(w);
        b8 = addr[0] ? d[15:8] : d[7:0];
        q.push_back('{1'b0, addr, 2'b00, 1'b0, 16'h0, d});
        exp_wb = {{8{b8[7]}}, b8};
      end
      MOP_STR: begin
        q.push_back('{1'b1, w, 2'b11, 1'b1, sd, 16'($urandom)});
        mem[w] = sd;
      end
      MOP_STB: begin
        be = addr[0] ? 2'b10 : 2'b01;
        q.push_back('{1'b1, addr, be, 1'b1, {2{sd[7:0]}}, 16'($urandom)});
        cur = rd(w);
        if (addr[0]) cur[15:8] = sd[7:0];
        else cur[7:0] = sd[7:0];
        mem[w] = cur;
      end
      MOP_LDI: begin
        p = rd(w);
        q.push_back('{1'b0, w, 2'b11, 1'b1, 16'h0, p});
        p = {p[15:1], 1'b0};
        d = rd(p);
        q.push_back('{1'b0, p, 2'b11, 1'b1, 16'h0, d});
        exp_wb = d;
      end
      MOP_STI: begin
        p = rd(w);
        q.push_back('{1'b0, w, 2'b11, 1'b1, 16'h0, p});
        p = {p[15:1], 1'b0};
        q.push_back('{1'b1, p, 2'b11, 1'b1, sd, 16'($urandom)});
        mem[p] = sd;
      end
      default: exp_wb = alu;
    endcase
    in_valid    = 1'b1;
    mem_op      = op;
    addr_in     = addr;
    alu_in      = alu;
    store_data  = sd;
    dest_in     = dest;
    regwrite_in = rw;
    if (q.size() == 0) begin
      @(negedge clk);
      check("none_req", {dmem_read, dmem_write}, 0);
      check("none_stall", stall, 0);
      @(posedge clk);
      #1;
    end else begin
      for (int a = 0; a < q.size(); a++) begin
        for (int c = 0; c <= lat; c++) begin
          @(negedge clk);
          check("req", {dmem_read, dmem_write, dmem_address}, {!q[a].we, q[a].we, q[a].addr});
          if (q[a].chk_be) check("byte_en", dmem_byte_en, q[a].be);
          if (q[a].we) check("wdata", dmem_wdata, q[a].wdata);
          if (a == 0 && c == 0) got_be = dmem_byte_en;
          last = (a == q.size() - 1) && (c == lat);
          if (c == lat) begin
            dmem_resp  = 1'b1;
            dmem_rdata = q[a].rdata;
          end else begin
            dmem_rdata = 16'($urandom);
          end
          #1;
          check("stall", stall, !last);
          @(posedge clk);
          #1;
          dmem_resp = 1'b0;
          if (!last) check("bubble", wb_valid, 0);
        end
      end
    end
    check("wb_valid", wb_valid, 1);
    check("wb_data", wb_data, exp_wb);
    check("wb_dest", wb_dest, dest);
    check("wb_regwrite", wb_regwrite, rw && !(op inside {MOP_STR, MOP_STB, MOP_STI}));
    got_wb   = wb_data;
    in_valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] gw;
    logic [1:0]  gb;
    lc3b_memop   ops[7];
    ops = '{MOP_NONE, MOP_LDR, MOP_LDB, MOP_STR, MOP_STB, MOP_LDI, MOP_STI};

    vecs[0] = '{MOP_NONE, 16'h0000, 16'h1234, 16'h0000, 16'h0, 16'h0, 3'd3, 1'b1, 0, 16'h1234, 1'b0, 2'b00};
    vecs[1] = '{MOP_LDR,  16'h3001, 16'h0,    16'h0000, 16'hBEEF, 16'h0, 3'd1, 1'b1, 2, 16'hBEEF, 1'b1, 2'b11};
    vecs[2] = '{MOP_LDB,  16'h2005, 16'h0,    16'h0000, 16'h8012, 16'h0, 3'd2, 1'b1, 0, 16'hFF80, 1'b0, 2'b00};
    vecs[3] = '{MOP_LDB,  16'h2004, 16'h0,    16'h0000, 16'h8012, 16'h0, 3'd4, 1'b1, 0, 16'h0012, 1'b0, 2'b00};
    vecs[4] = '{MOP_STB,  16'h4000, 16'h0,    16'hAB5C, 16'h0, 16'h0, 3'd5, 1'b1, 1, 16'h0000, 1'b1, 2'b01};
    vecs[5] = '{MOP_STB,  16'h4001, 16'h0,    16'hAB5C, 16'h0, 16'h0, 3'd6, 1'b1, 0, 16'h0000, 1'b1, 2'b10};
    vecs[6] = '{MOP_LDI,  16'h1000, 16'h0,    16'h0000, 16'h2000, 16'h7777, 3'd7, 1'b1, 1, 16'h7777, 1'b1, 2'b11};
    vecs[7] = '{MOP_STI,  16'h1000, 16'h0,    16'h1357, 16'h2000, 16'h0, 3'd0, 1'b0, 2, 16'h0000, 1'b1, 2'b11};
    vecs[8] = '{MOP_STR,  16'h5003, 16'h0,    16'hCAFE, 16'h0, 16'h0, 3'd2, 1'b1, 3, 16'h0000, 1'b1, 2'b11};

    // Reset state, and requests held off while reset is asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_dest", wb_dest, 0);
    check("rst_wb_regwrite", wb_regwrite, 0);
    in_valid = 1'b1;
    mem_op   = MOP_LDR;
    #1;
    check("rst_no_req", {dmem_read, dmem_write}, 0);
    in_valid = 1'b0;
    mem_op   = MOP_NONE;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].op != MOP_NONE) begin
        mem[{vecs[i].addr[15:1], 1'b0}] = vecs[i].rd1;
        if (is_indirect(vecs[i].op)) mem[{vecs[i].rd1[15:1], 1'b0}] = vecs[i].rd2;
      end
      do_op(vecs[i].op, vecs[i].addr, vecs[i].alu, vecs[i].sd, vecs[i].dest, vecs[i].rw,
            vecs[i].lat, gw, gb);
      check($sformatf("tbl%0d_wb", i), gw, vecs[i].exp_wb);
      if (vecs[i].chk_be) check($sformatf("tbl%0d_be", i), gb, vecs[i].exp_be);
    end

    // Reset while in the second access of an LDI abandons it.
    in_valid = 1'b1;
    mem_op   = MOP_LDI;
    addr_in  = 16'h1000;
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h2000;
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    check("ldi2_req", {dmem_read, dmem_address}, {1'b1, 16'h2000});
    reset = 1'b1;
    #1;
    check("rst_mid_read", {dmem_read, dmem_write}, 0);
    check("rst_mid_wb_valid", wb_valid, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h7777;
    #1;
    check("late_resp_req", {dmem_read, dmem_write, stall}, 0);
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    check("late_resp_wb", {wb_valid, wb_regwrite}, 0);
    // State is back in FIRST: next LDR must go to addr_in, not the stale pointer.
    mem[16'h1000] = 16'h2000;
    do_op(MOP_LDR, 16'h1000, 16'h0, 16'h0, 3'd1, 1'b1, 0, gw, gb);

    // Randomized traffic with occasional idle cycles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        mem_op   = ops[$urandom_range(0, 6)];
        @(negedge clk);
        check("idle_req", {dmem_read, dmem_write, stall}, 0);
        @(posedge clk);
        #1;
        check("idle_wb", {wb_valid, wb_regwrite}, 0);
      end
      do_op(ops[$urandom_range(0, 6)], {12'h300, 4'($urandom)}, 16'($urandom),
            16'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 3), gw, gb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
